// File: rtl/uart_rx_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_datapath_if
// Description : Received-byte status bundle from the UART RX datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_datapath_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] RX_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  framing_error;
    logic                  busy;

    modport master (
        output RX_data,
        output data_valid,
        output parity_error,
        output framing_error,
        output busy
    );

    modport slave (
        input RX_data,
        input data_valid,
        input parity_error,
        input framing_error,
        input busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_datapath.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_datapath
// Description : Oversampled UART receiver: start/data/parity/stop framing.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_datapath #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_TYPE = 0,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic         sample_tick,
    input  wire logic         parity_enable,
    input  wire logic         RX_in,
    uart_rx_datapath_if.master status_o
);

    localparam int c_tick_w = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_bit_w  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_tick_w-1:0] c_tick_mid  = c_tick_w'(OVERSAMPLE/2 - 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_WIDTH - 1);
    localparam logic                c_par_odd   = (PARITY_TYPE != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [c_tick_w-1:0]     tick_q, tick_d;
    logic [c_bit_w-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_en_q, par_en_d;
    logic                    par_mis_q, par_mis_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    valid_q, valid_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic                    rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Synchronizer resets to the idle (mark) level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX_in};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_mis_q <= 1'b0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_mis_q <= par_mis_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_mis_d = par_mis_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        if (sample_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == c_tick_mid) begin
                        tick_d = '0;
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_DATA;
                            bit_d     = '0;
                            par_en_d  = parity_enable;
                            par_mis_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_q == c_tick_last) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                        if (bit_q == c_bit_last) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick_q == c_tick_last) begin
                        tick_d    = '0;
                        par_mis_d = rx_s ^ (^shift_q) ^ c_par_odd;
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_q == c_tick_last) begin
                        tick_d    = '0;
                        rx_data_d = shift_q;
                        perr_d    = par_en_q & par_mis_q;
                        ferr_d    = ~rx_s;
                        valid_d   = 1'b1;
                        state_d   = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A line held low must return high before another start is honoured.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    assign status_o.RX_data       = rx_data_q;
    assign status_o.data_valid    = valid_q;
    assign status_o.parity_error  = perr_q;
    assign status_o.framing_error = ferr_q;
    assign status_o.busy          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_datapath
// Description : Randomized and directed frames against even/odd parity receivers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_datapath;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pbit;
        logic       stop;
    } frame_t;

    logic clk;
    logic reset_n;
    logic sample_tick;
    logic parity_enable;
    logic RX_in;

    int   checks   = 0;
    int   failures = 0;
    int   tick_div = 1;
    int   div_cnt  = 0;
    int   idx0     = 0;
    int   idx1     = 0;
    int   len0     = 0;
    int   len1     = 0;
    frame_t sent[$];

    uart_rx_datapath_if #(.DATA_WIDTH(8)) st0 ();
    uart_rx_datapath_if #(.DATA_WIDTH(8)) st1 ();

    uart_rx_datapath #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_TYPE(0), .SYNC_STAGES(2)) u_dut0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_tick   (sample_tick),
        .parity_enable (parity_enable),
        .RX_in         (RX_in),
        .status_o      (st0)
    );

    uart_rx_datapath #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_TYPE(1), .SYNC_STAGES(2)) u_dut1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_tick   (sample_tick),
        .parity_enable (parity_enable),
        .RX_in         (RX_in),
        .status_o      (st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        sample_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (div_cnt + 1 >= tick_div) begin
                div_cnt     = 0;
                sample_tick = 1'b1;
            end else begin
                div_cnt     = div_cnt + 1;
                sample_tick = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic exp_perr(input frame_t f, input int pt);
        logic want;
        want = (^f.data) ^ (pt != 0);
        return f.pe && (f.pbit != want);
    endfunction

    task automatic tick_wait(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (sample_tick !== 1'b1);
            #2;
        end
    endtask

    task automatic hold_bit(input logic b);
        RX_in = b;
        tick_wait(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit, input logic stop);
        frame_t f;
        f.data = d; f.pe = pe; f.pbit = pbit; f.stop = stop;
        sent.push_back(f);
        parity_enable = pe;
        hold_bit(1'b0);
        parity_enable = 1'($urandom);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        if (pe) hold_bit(pbit);
        hold_bit(stop);
    endtask

    task automatic check_held(input string tag);
        frame_t f;
        f = sent[sent.size()-1];
        check_eq({tag, "_data0"}, 32'(st0.RX_data), 32'(f.data));
        check_eq({tag, "_ferr0"}, 32'(st0.framing_error), 32'(!f.stop));
        check_eq({tag, "_perr0"}, 32'(st0.parity_error), 32'(exp_perr(f, 0)));
        check_eq({tag, "_perr1"}, 32'(st1.parity_error), 32'(exp_perr(f, 1)));
    endtask

    always @(posedge clk) begin
        #1;
        if (st0.data_valid) begin
            len0 = len0 + 1;
            if (len0 == 1) begin
                check_eq("valid_count0", idx0 + 1, sent.size());
                if (idx0 < sent.size()) begin
                    check_eq("rx_data0", 32'(st0.RX_data), 32'(sent[idx0].data));
                    check_eq("parity_err0", 32'(st0.parity_error), 32'(exp_perr(sent[idx0], 0)));
                    check_eq("framing_err0", 32'(st0.framing_error), 32'(!sent[idx0].stop));
                end
                idx0 = idx0 + 1;
            end
        end else if (len0 != 0) begin
            check_eq("valid_width0", len0, 1);
            len0 = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (st1.data_valid) begin
            len1 = len1 + 1;
            if (len1 == 1) begin
                check_eq("valid_count1", idx1 + 1, sent.size());
                if (idx1 < sent.size()) begin
                    check_eq("rx_data1", 32'(st1.RX_data), 32'(sent[idx1].data));
                    check_eq("parity_err1", 32'(st1.parity_error), 32'(exp_perr(sent[idx1], 1)));
                    check_eq("framing_err1", 32'(st1.framing_error), 32'(!sent[idx1].stop));
                end
                idx1 = idx1 + 1;
            end
        end else if (len1 != 0) begin
            check_eq("valid_width1", len1, 1);
            len1 = 0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        RX_in         = 1'b1;
        parity_enable = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_data",  32'(st0.RX_data), 32'h0);
        check_eq("rst_valid", 32'(st0.data_valid), 32'h0);
        check_eq("rst_perr",  32'(st0.parity_error), 32'h0);
        check_eq("rst_ferr",  32'(st0.framing_error), 32'h0);
        check_eq("rst_busy",  32'(st0.busy), 32'h0);
        reset_n = 1'b1;
        tick_wait(4);
        check_eq("idle_busy", 32'(st0.busy), 32'h0);

        // Plain 8N1 frame.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        check_eq("t1_busy", 32'(st0.busy), 32'h0);
        check_held("t1");
        tick_wait(3);

        // Parity: 0xA5 has even weight, so bit 0 suits even, bit 1 suits odd.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        tick_wait(2);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        tick_wait(2);
        check_held("t2");

        // Glitch shorter than half a bit.
        RX_in = 1'b0;
        tick_wait(4);
        check_eq("glitch_busy_hi", 32'(st0.busy), 32'h1);
        RX_in = 1'b1;
        tick_wait(20);
        check_eq("glitch_busy_lo", 32'(st0.busy), 32'h0);
        check_held("glitch");

        // Stop bit low, line held low as a break, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick_wait(40);
        check_eq("break_busy", 32'(st0.busy), 32'h1);
        check_held("break");
        RX_in = 1'b1;
        tick_wait(4);
        check_eq("break_exit", 32'(st0.busy), 32'h0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        tick_wait(2);

        // Reset in the middle of data bit 4 of 0xFF.
        parity_enable = 1'b0;
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b1);
        RX_in = 1'b1;
        tick_wait(8);
        check_eq("mid_busy", 32'(st0.busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_data", 32'(st0.RX_data), 32'h0);
        check_eq("mid_rst_busy", 32'(st0.busy), 32'h0);
        check_eq("mid_rst_ferr", 32'(st0.framing_error), 32'h0);
        check_eq("mid_rst_valid", 32'(st0.data_valid), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick_wait(20);
        check_eq("post_rst_busy", 32'(st0.busy), 32'h0);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        tick_wait(2);

        // Back-to-back at one tick every three clocks.
        tick_div = 3;
        tick_wait(2);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        tick_wait(4);
        check_held("b2b");

        // Random frames with random tick spacing, parity and framing.
        for (int n = 0; n < 16; n++) begin
            logic [7:0] d;
            logic       pe, pb, sb;
            tick_div = $urandom_range(1, 3);
            d  = 8'($urandom);
            pe = 1'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 5) != 0);
            send_frame(d, pe, pb, sb);
            if (!sb) begin
                tick_wait($urandom_range(0, 6));
                RX_in = 1'b1;
                tick_wait(3);
            end else begin
                tick_wait($urandom_range(0, 2));
            end
        end

        tick_wait(40);
        check_held("final");
        check_eq("frames_seen0", idx0, sent.size());
        check_eq("frames_seen1", idx1, sent.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
